// File: rtl/qeciphy_pkg.sv
// Shared constants and types for the QECIPHY user-side blocks.
// Holds the PHY status code for a usable link and the TX feeder state encoding.
package qeciphy_pkg;

  localparam logic [3:0] QECIPHY_STATUS_LINK_READY = 4'h3;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    UP_REQ = 3'd1,
    UP_REL = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    DN_REQ = 3'd5,
    DN_REL = 3'd6
  } feeder_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/qeciphy_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word and
// a registered occupancy count. Pointers carry an extra wrap bit.
module qeciphy_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;

  // The head register is loaded with whatever word will be at the read
  // pointer after this edge, bypassing the write when it lands there.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_wr);
    rd_ptr_d = rd_ptr_q + PW'(do_rd);
    fill_d   = fill_q + PW'(do_wr) - PW'(do_rd);
    head_d   = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      if (do_wr && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = wr_data_i;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = head_q;
  assign fill_o    = fill_q;

endmodule

// File: rtl/qeciphy_tx_feeder.sv
// Buffers user words toward the PHY TX stream, gates delivery on LINK_READY
// and sequences the P-channel power handshake from a level power request.
module qeciphy_tx_feeder
  import qeciphy_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int ACCEPT_TIMEOUT = 4096
) (
  input  logic                     ACLK,
  input  logic                     ARSTn,
  input  logic [63:0]              S_TDATA,
  input  logic                     S_TVALID,
  output logic                     S_TREADY,
  output logic [63:0]              M_TDATA,
  output logic                     M_TVALID,
  input  logic                     M_TREADY,
  input  logic [3:0]               I_STATUS,
  input  logic                     I_PWR_ON,
  output logic                     PREQ,
  output logic                     PSTATE,
  input  logic                     PACCEPT,
  output logic [$clog2(DEPTH):0]   O_FILL,
  output logic [15:0]              O_DROP_CNT,
  output logic                     O_PWR_TIMEOUT,
  output logic                     O_RUN
);

  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);

  feeder_state_t state_q, state_d;
  logic          preq_q, preq_d;
  logic          pstate_q, pstate_d;
  logic          run_q, run_d;
  logic [15:0]   drop_q, drop_d;
  logic          tmo_q, tmo_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic          link_ok, in_hs, drop_pop;
  logic          wr_en, rd_en, full, empty;

  qeciphy_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_i     (ACLK),
    .rst_ni    (ARSTn),
    .wr_en_i   (wr_en),
    .wr_data_i (S_TDATA),
    .rd_en_i   (rd_en),
    .rd_data_o (M_TDATA),
    .full_o    (full),
    .empty_o   (empty),
    .fill_o    (O_FILL)
  );

  assign link_ok  = (I_STATUS == QECIPHY_STATUS_LINK_READY);
  assign S_TREADY = (state_q == RUN) && !full;
  assign M_TVALID = !empty && link_ok && ((state_q == RUN) || (state_q == DRAIN));
  assign in_hs    = (state_q == UP_REQ) || (state_q == UP_REL) ||
                    (state_q == DN_REQ) || (state_q == DN_REL);

  // While draining with no usable link, undeliverable words are discarded
  // one per cycle; a renewed power request takes priority over dropping.
  assign drop_pop = (state_q == DRAIN) && !I_PWR_ON && !empty && !link_ok;
  assign wr_en    = S_TVALID && S_TREADY;
  assign rd_en    = (M_TVALID && M_TREADY) || drop_pop;

  always_comb begin
    state_d  = state_q;
    preq_d   = preq_q;
    pstate_d = pstate_q;
    run_d    = run_q;
    case (state_q)
      OFF: begin
        if (I_PWR_ON) begin
          state_d  = UP_REQ;
          preq_d   = 1'b1;
          pstate_d = 1'b1;
        end
      end
      UP_REQ: begin
        if (PACCEPT) begin
          state_d = UP_REL;
          preq_d  = 1'b0;
        end
      end
      UP_REL: begin
        if (!PACCEPT) begin
          state_d = RUN;
          run_d   = 1'b1;
        end
      end
      RUN: begin
        if (!I_PWR_ON) begin
          state_d = DRAIN;
          run_d   = 1'b0;
        end
      end
      DRAIN: begin
        if (I_PWR_ON) begin
          state_d = RUN;
          run_d   = 1'b1;
        end else if (empty) begin
          state_d  = DN_REQ;
          preq_d   = 1'b1;
          pstate_d = 1'b0;
        end
      end
      DN_REQ: begin
        if (PACCEPT) begin
          state_d = DN_REL;
          preq_d  = 1'b0;
        end
      end
      DN_REL: begin
        if (!PACCEPT) begin
          state_d = OFF;
        end
      end
      default: begin
        state_d  = OFF;
        preq_d   = 1'b0;
        pstate_d = 1'b0;
        run_d    = 1'b0;
      end
    endcase
  end

  // Timeout only flags; PREQ stays up because P-channel cannot withdraw.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_d != state_q) begin
      tcnt_d = '0;
    end else if (in_hs && (tcnt_q != TW'(ACCEPT_TIMEOUT))) begin
      tcnt_d = tcnt_q + 1'b1;
    end
    tmo_d  = tmo_q || (in_hs && (tcnt_q == TW'(ACCEPT_TIMEOUT - 1)));
    drop_d = drop_pop ? sat_inc16(drop_q) : drop_q;
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q  <= OFF;
      preq_q   <= 1'b0;
      pstate_q <= 1'b0;
      run_q    <= 1'b0;
      drop_q   <= '0;
      tmo_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      preq_q   <= preq_d;
      pstate_q <= pstate_d;
      run_q    <= run_d;
      drop_q   <= drop_d;
      tmo_q    <= tmo_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign PREQ          = preq_q;
  assign PSTATE        = pstate_q;
  assign O_RUN         = run_q;
  assign O_DROP_CNT    = drop_q;
  assign O_PWR_TIMEOUT = tmo_q;

endmodule

// File: tb/tb_qeciphy_tx_feeder.sv
// Bench for qeciphy_tx_feeder: directed phases plus a random soak, all
// checked against a queue-based reference of the feeder's behaviour.
module tb_qeciphy_tx_feeder;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  localparam int M_OFF = 0, M_UPREQ = 1, M_UPREL = 2, M_RUN = 3,
                 M_DRAIN = 4, M_DNREQ = 5, M_DNREL = 6;

  logic        ACLK = 1'b0;
  logic        ARSTn;
  logic [63:0] S_TDATA;
  logic        S_TVALID;
  logic        S_TREADY;
  logic [63:0] M_TDATA;
  logic        M_TVALID;
  logic        M_TREADY;
  logic [3:0]  I_STATUS;
  logic        I_PWR_ON;
  logic        PREQ;
  logic        PSTATE;
  logic        PACCEPT;
  logic [4:0]  O_FILL;
  logic [15:0] O_DROP_CNT;
  logic        O_PWR_TIMEOUT;
  logic        O_RUN;

  qeciphy_tx_feeder #(
    .DEPTH          (DEPTH),
    .ACCEPT_TIMEOUT (TMO)
  ) dut (
    .ACLK          (ACLK),
    .ARSTn         (ARSTn),
    .S_TDATA       (S_TDATA),
    .S_TVALID      (S_TVALID),
    .S_TREADY      (S_TREADY),
    .M_TDATA       (M_TDATA),
    .M_TVALID      (M_TVALID),
    .M_TREADY      (M_TREADY),
    .I_STATUS      (I_STATUS),
    .I_PWR_ON      (I_PWR_ON),
    .PREQ          (PREQ),
    .PSTATE        (PSTATE),
    .PACCEPT       (PACCEPT),
    .O_FILL        (O_FILL),
    .O_DROP_CNT    (O_DROP_CNT),
    .O_PWR_TIMEOUT (O_PWR_TIMEOUT),
    .O_RUN         (O_RUN)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [63:0] mq[$];
  int          ms, mcnt, mdrop, rx_cnt;
  bit          mtmo, acc;
  // PHY responder state
  bit          phy_en;
  int          hi_cnt, lo_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ms = M_OFF; mcnt = 0; mdrop = 0; mtmo = 0; acc = 0;
    hi_cnt = 0; lo_cnt = 0;
  endtask

  // Compare every output against the model, then advance the model one cycle.
  task automatic model_step();
    bit link, e_srdy, e_mvld, w, r, d, hs;
    int n, ns;
    link   = (I_STATUS == 4'h3);
    n      = mq.size();
    e_srdy = (ms == M_RUN) && (n < DEPTH);
    e_mvld = (n > 0) && link && (ms == M_RUN || ms == M_DRAIN);
    chk("preq",     PREQ,     (ms == M_UPREQ || ms == M_DNREQ));
    chk("pstate",   PSTATE,   (ms >= M_UPREQ && ms <= M_DRAIN));
    chk("run",      O_RUN,    (ms == M_RUN));
    chk("s_tready", S_TREADY, e_srdy);
    chk("m_tvalid", M_TVALID, e_mvld);
    chk("fill",     O_FILL,   n);
    chk("drop",     O_DROP_CNT, mdrop);
    chk("tmo",      O_PWR_TIMEOUT, mtmo);
    if (e_mvld) chk("m_tdata", M_TDATA, mq[0]);

    w = S_TVALID && e_srdy;
    r = e_mvld && M_TREADY;
    d = (ms == M_DRAIN) && !I_PWR_ON && (n > 0) && !link;
    acc = w;
    if (r || d) begin
      void'(mq.pop_front());
      if (r) rx_cnt++;
      if (d && mdrop < 65535) mdrop++;
    end
    if (w) mq.push_back(S_TDATA);

    ns = ms;
    case (ms)
      M_OFF:   if (I_PWR_ON) ns = M_UPREQ;
      M_UPREQ: if (PACCEPT)  ns = M_UPREL;
      M_UPREL: if (!PACCEPT) ns = M_RUN;
      M_RUN:   if (!I_PWR_ON) ns = M_DRAIN;
      M_DRAIN: if (I_PWR_ON) ns = M_RUN; else if (n == 0) ns = M_DNREQ;
      M_DNREQ: if (PACCEPT)  ns = M_DNREL;
      default: if (!PACCEPT) ns = M_OFF;
    endcase
    hs = (ms == M_UPREQ || ms == M_UPREL || ms == M_DNREQ || ms == M_DNREL);
    if (hs) begin
      mcnt++;
      if (mcnt >= TMO) mtmo = 1;
    end
    if (ns != ms) mcnt = 0;
    ms = ns;
  endtask

  // PHY: accept 3 cycles after PREQ rises, release 2 cycles after it falls.
  task automatic phy_drive();
    if (PREQ) begin hi_cnt++; lo_cnt = 0; end
    else begin lo_cnt++; hi_cnt = 0; end
    if (!phy_en) PACCEPT = 1'b0;
    else if (PREQ) PACCEPT = (hi_cnt >= 3);
    else PACCEPT = PACCEPT && (lo_cnt < 2);
  endtask

  task automatic tick();
    @(negedge ACLK);
    model_step();
    @(posedge ACLK);
    #1;
    phy_drive();
  endtask

  task automatic push_n(input int cnt);
    int pushed = 0;
    for (int i = 0; i < 100 && pushed < cnt; i++) begin
      S_TVALID = 1'b1;
      S_TDATA  = {$urandom, $urandom};
      tick();
      if (acc) pushed++;
    end
    S_TVALID = 1'b0;
    chk("push_n", pushed, cnt);
  endtask

  task automatic drain_all();
    M_TREADY = 1'b1;
    for (int i = 0; i < 100 && mq.size() != 0; i++) tick();
    tick();
    chk("drain_empty", O_FILL, 0);
  endtask

  task automatic do_reset();
    ARSTn = 1'b0;
    S_TVALID = 0; S_TDATA = '0; M_TREADY = 0; I_PWR_ON = 0; PACCEPT = 0;
    I_STATUS = 4'h3;
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    ARSTn = 1'b1;
  endtask

  initial begin
    logic [63:0] head;
    int          idx, drop0, base;
    bit          filled;

    rx_cnt = 0;
    phy_en = 1;
    ARSTn  = 1'b0;
    S_TVALID = 0; S_TDATA = '0; M_TREADY = 0; I_PWR_ON = 0; PACCEPT = 0;
    I_STATUS = 4'h3;
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_preq",   PREQ, 0);
    chk("rst_pstate", PSTATE, 0);
    chk("rst_srdy",   S_TREADY, 0);
    chk("rst_mvld",   M_TVALID, 0);
    chk("rst_mdata",  M_TDATA, 0);
    chk("rst_fill",   O_FILL, 0);
    chk("rst_drop",   O_DROP_CNT, 0);
    chk("rst_tmo",    O_PWR_TIMEOUT, 0);
    chk("rst_run",    O_RUN, 0);
    ARSTn = 1'b1;
    tick();

    // power-up handshake
    I_PWR_ON = 1'b1;
    for (int i = 0; i < 10 && !PREQ; i++) tick();
    chk("up_preq", PREQ, 1);
    chk("up_pstate_same", PSTATE, 1);
    for (int i = 0; i < 10 && !PACCEPT; i++) tick();
    chk("up_paccept", PACCEPT, 1);
    tick();
    chk("up_preq_fall", PREQ, 0);
    for (int i = 0; i < 20 && ms != M_RUN; i++) tick();
    chk("up_run", O_RUN, 1);

    // data path: 20 ordered words, sink stalled until full then 50% ready
    base = rx_cnt; idx = 1; filled = 0;
    S_TVALID = 1; S_TDATA = 64'd1; M_TREADY = 0;
    for (int i = 0; i < 400 && !(idx > 20 && mq.size() == 0); i++) begin
      tick();
      if (acc) idx++;
      if (idx > 20) S_TVALID = 0; else S_TDATA = 64'(idx);
      if (!filled && mq.size() == DEPTH) begin
        chk("full_fill", O_FILL, DEPTH);
        chk("full_srdy", S_TREADY, 0);
        filled = 1;
      end
      M_TREADY = filled ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    S_TVALID = 0;
    chk("data_rx20", rx_cnt - base, 20);

    // link drop with 5 buffered words
    M_TREADY = 0;
    push_n(5);
    tick();
    head = mq[0];
    I_STATUS = 4'h1; M_TREADY = 1;
    #1;
    chk("ld_mvld_low", M_TVALID, 0);
    repeat (3) tick();
    chk("ld_fill5", O_FILL, 5);
    I_STATUS = 4'h3;
    #1;
    chk("ld_resume_vld", M_TVALID, 1);
    chk("ld_resume_head", M_TDATA, head);
    drain_all();

    // drain abort: words held by a stalled sink, power request bounces
    M_TREADY = 0;
    push_n(3);
    drop0 = mdrop;
    I_PWR_ON = 0;
    tick();
    chk("ab_in_drain", O_RUN, 0);
    I_PWR_ON = 1;
    tick();
    chk("ab_run", O_RUN, 1);
    chk("ab_preq", PREQ, 0);
    chk("ab_drop", O_DROP_CNT, drop0);
    chk("ab_fill", O_FILL, 3);
    drain_all();

    // drain and drop: 6 words, link down, power off
    M_TREADY = 0;
    push_n(6);
    drop0 = mdrop;
    I_STATUS = 4'h1; I_PWR_ON = 0;
    for (int i = 0; i < 50 && ms != M_DNREQ; i++) tick();
    chk("dd_drop6", O_DROP_CNT, drop0 + 6);
    chk("dd_preq", PREQ, 1);
    chk("dd_pstate", PSTATE, 0);
    for (int i = 0; i < 50 && ms != M_OFF; i++) tick();
    tick();
    chk("dd_off_preq", PREQ, 0);
    chk("dd_off_pstate", PSTATE, 0);
    chk("dd_off_run", O_RUN, 0);
    I_STATUS = 4'h3;

    // random soak
    for (int i = 0; i < 600; i++) begin
      S_TVALID = 1'($urandom_range(0, 1));
      S_TDATA  = {$urandom, $urandom};
      M_TREADY = ($urandom_range(0, 9) < 6);
      I_STATUS = ($urandom_range(0, 9) < 8) ? 4'h3 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) I_PWR_ON = !I_PWR_ON;
      tick();
    end
    S_TVALID = 0;

    // timeout with PACCEPT stuck low, then reset mid-handshake
    do_reset();
    phy_en = 0;
    tick();
    I_PWR_ON = 1;
    for (int i = 0; i < 20 && !PREQ; i++) tick();
    chk("to_preq", PREQ, 1);
    repeat (7) tick();
    chk("to_before", O_PWR_TIMEOUT, 0);
    tick();
    chk("to_flag", O_PWR_TIMEOUT, 1);
    chk("to_preq_held", PREQ, 1);
    repeat (3) tick();
    chk("to_sticky", O_PWR_TIMEOUT, 1);
    ARSTn = 1'b0;
    #1;
    chk("mr_preq", PREQ, 0);
    chk("mr_pstate", PSTATE, 0);
    chk("mr_tmo", O_PWR_TIMEOUT, 0);
    chk("mr_run", O_RUN, 0);
    chk("mr_fill", O_FILL, 0);
    chk("mr_mvld", M_TVALID, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qeciphy_tx_feeder.md
Name: qeciphy_tx_feeder

Overview:
- Upstream neighbour of the PHY top: sits between user logic and the PHY's TX AXI-Stream and P-channel ports, in the ACLK domain.
- Buffers user 64-bit words in a FIFO and forwards them only while the link reports LINK_READY.
- Sequences the PHY's four-phase P-channel handshake (PREQ/PSTATE/PACCEPT) from a simple level power request.
- On power-down, drains the buffer before requesting power-down; words that cannot be delivered are dropped and counted.

Parameters:
- DEPTH, 16, FIFO depth in 64-bit words; power of 2, ≥ 4.
- ACCEPT_TIMEOUT, 4096, ACLK cycles to wait for a PACCEPT edge before flagging timeout.

Ports:
- ACLK  in  1  single clock for the whole block.
- ARSTn  in  1  asynchronous, active-low reset.
- S_TDATA  in  64  user data.
- S_TVALID  in  1  user valid.
- S_TREADY  out  1  ready to user.
- M_TDATA  out  64  to PHY TX_TDATA.
- M_TVALID  out  1  to PHY TX_TVALID.
- M_TREADY  in  1  from PHY TX_TREADY.
- I_STATUS  in  4  PHY STATUS.
- I_PWR_ON  in  1  level; 1 = link wanted up.
- PREQ  out  1  to PHY PREQ.
- PSTATE  out  1  to PHY PSTATE; 1 = on, 0 = off.
- PACCEPT  in  1  from PHY.
- O_FILL  out  $clog2(DEPTH)+1  FIFO occupancy.
- O_DROP_CNT  out  16  saturating count of discarded words.
- O_PWR_TIMEOUT  out  1  sticky; PACCEPT edge not seen within ACCEPT_TIMEOUT.
- O_RUN  out  1  high in RUN state.

Behaviour:
- Reset: state OFF; PREQ=0, PSTATE=0, S_TREADY=0, M_TVALID=0, M_TDATA=0, O_FILL=0, O_DROP_CNT=0, O_PWR_TIMEOUT=0, O_RUN=0. FIFO pointers are cleared asynchronously.
- FIFO:
  - First-word-fall-through.
  - Write when S_TVALID && S_TREADY; S_TREADY = (state==RUN) && !full.
  - Read when M_TVALID && M_TREADY.
  - Simultaneous read and write leaves fill unchanged.
  - Pointers are $clog2(DEPTH)+1 bits with an extra wrap bit; full/empty are derived from the pointers.
- Gate:
  - link_ok = (I_STATUS == QECIPHY_STATUS_LINK_READY).
  - M_TVALID = !empty && link_ok && state∈{RUN, DRAIN}.
  - M_TDATA is valid whenever M_TVALID is high and is held stable while M_TVALID && !M_TREADY.
  - A link_ok drop while M_TVALID is high deasserts M_TVALID; the word stays in the FIFO.
- State machine:
  - OFF: PREQ=0, PSTATE=0. I_PWR_ON=1 → UP_REQ.
  - UP_REQ: PSTATE=1 set the same cycle as PREQ=1. PACCEPT=1 → UP_REL.
  - UP_REL: PREQ=0, PSTATE held at 1. PACCEPT=0 → RUN.
  - RUN: O_RUN=1. I_PWR_ON=0 → DRAIN.
  - DRAIN: S_TREADY=0.
    - I_PWR_ON=1 → RUN (abort; nothing dropped).
    - empty → DN_REQ.
    - If !link_ok, pop one word per cycle and increment O_DROP_CNT (saturates at 0xFFFF).
  - DN_REQ: PSTATE=0 set the same cycle as PREQ=1. PACCEPT=1 → DN_REL.
  - DN_REL: PREQ=0. PACCEPT=0 → OFF.
- I_PWR_ON changes in UP_REQ/UP_REL/DN_REQ/DN_REL are ignored until the handshake completes.
- PSTATE never changes while PREQ=1.
- Timeout:
  - A counter runs in UP_REQ, UP_REL, DN_REQ and DN_REL; it clears on every state change.
  - At ACCEPT_TIMEOUT cycles, O_PWR_TIMEOUT=1 (sticky until ARSTn).
  - The handshake continues: PREQ is held, because P-channel has no withdraw.
- Latency: the first word written in RUN appears on M_TVALID 1 cycle after the write, given link_ok.
- All outputs are registered except S_TREADY and M_TVALID, which are combinational from registered state.

Decomposition:
- qeciphy_pkg holds:
  - QECIPHY_STATUS_LINK_READY (4'h3);
  - typedef enum feeder_state_t {OFF, UP_REQ, UP_REL, RUN, DRAIN, DN_REQ, DN_REL}.
- One sub-module: qeciphy_sync_fifo (DEPTH, WIDTH params; FWFT; fill output). It is reusable on the RX side.

Test Plan:
- Power-up, directed sequence:
  - Stimulus: reset; I_PWR_ON=1; PHY model asserts PACCEPT 3 cycles after PREQ, then drops it 2 cycles after PREQ falls.
  - Expected: PREQ=1 with PSTATE=1 in the same cycle; PREQ falls on PACCEPT; O_RUN=1 after PACCEPT falls.
- Data path, directed sequence:
  - Stimulus: in RUN with I_STATUS=3, write 20 words 0x1..0x14 with M_TREADY toggling 50%.
  - Expected: S_TREADY=0 once fill reaches 16; words are received in order and none are lost.
- Link drop:
  - Stimulus: I_STATUS goes 3→1 with 5 words buffered.
  - Expected: M_TVALID=0 next cycle and O_FILL stays 5; on I_STATUS=3, delivery resumes with the same head word.
- Drain and drop:
  - Stimulus: 6 words buffered; I_PWR_ON=0 with I_STATUS=1.
  - Expected: O_DROP_CNT=6, then DN_REQ with PSTATE=0; after the handshake the state is OFF.
- Drain abort:
  - Stimulus: in DRAIN, re-assert I_PWR_ON.
  - Expected: return to RUN with no PREQ pulse and O_DROP_CNT unchanged.
- Timeout and mid-operation reset:
  - Stimulus: PACCEPT tied 0 with ACCEPT_TIMEOUT=8.
  - Expected: O_PWR_TIMEOUT=1 at cycle 8 with PREQ still 1; asserting ARSTn=0 mid-handshake clears all outputs immediately.
